// File: rtl/sha256_msg_pad.sv
// Streaming SHA-256 message padder: packs 32-bit big-endian words into 512-bit
// blocks and appends the 0x80 marker, zero fill and the 64-bit bit length.
module sha256_msg_pad #(
  parameter int unsigned LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last,
  output logic         busy
);

  typedef enum logic [1:0] {FILL, SEND, PADBLK} state_t;

  state_t           state_q;
  logic [3:0]       w_q;
  logic [LEN_W-1:0] len_q;
  logic             first_q, last_q, pad_pend_q, pad80_q;
  logic             in_ready_q, blk_valid_q;
  logic [31:0]      blk_q [16];

  logic [2:0]       n_d;
  logic [6:0]       p_d;
  logic [31:0]      masked_d;
  logic [LEN_W-1:0] len_n_d;
  logic [63:0]      bits_n_d;
  logic [31:0]      last_blk_d [16];

  // Bit length (bytes*8, modulo 2^LEN_W), zero-extended to the 64-bit field.
  function automatic logic [63:0] bitlen(input logic [LEN_W-1:0] bytes);
    logic [LEN_W-1:0] b;
    b = bytes << 3;
    return 64'(b);
  endfunction

  always_comb begin
    n_d = (in_bytes == 3'd0 || in_bytes > 3'd4) ? 3'd4 : in_bytes;
    p_d = {1'b0, w_q, 2'b00} + {4'b0000, n_d};
    len_n_d  = len_q + LEN_W'(n_d);
    bits_n_d = bitlen(len_n_d);
    case (n_d)
      3'd1:    masked_d = {in_data[31:24], 8'h80, 16'h0000};
      3'd2:    masked_d = {in_data[31:16], 8'h80, 8'h00};
      3'd3:    masked_d = {in_data[31:8], 8'h80};
      default: masked_d = in_data;
    endcase
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < 32'(w_q))
        last_blk_d[i] = blk_q[i];
      else if (i == 32'(w_q))
        last_blk_d[i] = masked_d;
      else if (i == 32'(w_q) + 1 && n_d == 3'd4)
        last_blk_d[i] = 32'h8000_0000;
      else
        last_blk_d[i] = '0;
    end
    if (p_d <= 7'd55) begin
      last_blk_d[14] = bits_n_d[63:32];
      last_blk_d[15] = bits_n_d[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      w_q         <= '0;
      len_q       <= '0;
      first_q     <= 1'b1;
      last_q      <= 1'b0;
      pad_pend_q  <= 1'b0;
      pad80_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      blk_valid_q <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) blk_q[i] <= '0;
    end else begin
      case (state_q)
        FILL: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            if (in_last) begin
              for (int unsigned i = 0; i < 16; i++) blk_q[i] <= last_blk_d[i];
              len_q       <= len_n_d;
              w_q         <= '0;
              state_q     <= SEND;
              in_ready_q  <= 1'b0;
              blk_valid_q <= 1'b1;
              if (p_d <= 7'd55) begin
                last_q     <= 1'b1;
                pad_pend_q <= 1'b0;
              end else begin
                last_q     <= 1'b0;
                pad_pend_q <= 1'b1;
                pad80_q    <= (p_d == 7'd64);
              end
            end else begin
              blk_q[w_q] <= in_data;
              w_q        <= w_q + 4'd1;
              len_q      <= len_q + LEN_W'(4);
              if (w_q == 4'd15) begin
                state_q     <= SEND;
                in_ready_q  <= 1'b0;
                blk_valid_q <= 1'b1;
                last_q      <= 1'b0;
              end
            end
          end
        end
        SEND: begin
          if (blk_ready) begin
            blk_valid_q <= 1'b0;
            w_q         <= '0;
            if (last_q) begin
              len_q   <= '0;
              first_q <= 1'b1;
            end else begin
              first_q <= 1'b0;
            end
            if (pad_pend_q) begin
              state_q <= PADBLK;
            end else begin
              state_q    <= FILL;
              in_ready_q <= 1'b1;
            end
          end
        end
        PADBLK: begin
          for (int unsigned i = 0; i < 16; i++) blk_q[i] <= '0;
          blk_q[0]    <= pad80_q ? 32'h8000_0000 : 32'h0;
          blk_q[14]   <= bitlen(len_q) >> 32;
          blk_q[15]   <= bitlen(len_q) & 64'hFFFF_FFFF;
          last_q      <= 1'b1;
          pad_pend_q  <= 1'b0;
          state_q     <= SEND;
          blk_valid_q <= 1'b1;
        end
        default: state_q <= FILL;
      endcase
    end
  end

  always_comb begin
    blk_data = '0;
    for (int unsigned i = 0; i < 16; i++) blk_data[511-32*i -: 32] = blk_q[i];
  end

  assign in_ready  = in_ready_q;
  assign blk_valid = blk_valid_q;
  // Flags are qualified by valid so they read 0 in reset and between blocks.
  assign blk_first = first_q & blk_valid_q;
  assign blk_last  = last_q & blk_valid_q;
  assign busy      = (state_q != FILL) || (w_q != 4'd0) || pad_pend_q;

endmodule

// File: tb/tb_sha256_msg_pad.sv
// Directed bench for sha256_msg_pad: table of single-word messages plus
// hand-written multi-block, backpressure, back-to-back and reset sequences.
module tb_sha256_msg_pad;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic [2:0]   in_bytes = '0;
  logic         blk_valid;
  logic         blk_ready = 1'b0;
  logic [511:0] blk_data;
  logic         blk_first, blk_last, busy;

  int checks = 0;
  int failures = 0;

  sha256_msg_pad #(.LEN_W(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  nb;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w15;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic check_blk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] put(input logic [511:0] b, input int unsigned k,
                                       input logic [31:0] v);
    b[511-32*k -: 32] = v;
    return b;
  endfunction

  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int cyc = 0;
    in_data  = d;
    in_last  = last;
    in_bytes = nb;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!in_ready) begin
      check("send_timeout", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_block(output logic [511:0] d, output logic f, output logic l);
    int cyc = 0;
    @(negedge clk);
    while (!blk_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!blk_valid) begin
      check("blk_timeout", {63'd0, blk_valid}, 64'd1);
      d = '0; f = 1'b0; l = 1'b0;
      return;
    end
    d = blk_data; f = blk_first; l = blk_last;
    blk_ready = 1'b1;
    @(posedge clk);
    #1;
    blk_ready = 1'b0;
  endtask

  logic [511:0] got, exp, hold_d;
  logic         gf, gl;
  logic [31:0]  pat [4];

  initial begin
    vecs[0] = '{32'h61626300, 3'd3, 32'h61626380, 32'h0, 32'h18};
    vecs[1] = '{32'h41000000, 3'd1, 32'h41800000, 32'h0, 32'h08};
    vecs[2] = '{32'h41420000, 3'd2, 32'h41428000, 32'h0, 32'h10};
    vecs[3] = '{32'hDEADBEEF, 3'd4, 32'hDEADBEEF, 32'h80000000, 32'h20};
    vecs[4] = '{32'h01020304, 3'd0, 32'h01020304, 32'h80000000, 32'h20};
    vecs[5] = '{32'hAABBCCDD, 3'd3, 32'hAABBCC80, 32'h0, 32'h18};
    pat[0] = 32'h34333232; pat[1] = 32'h31323335;
    pat[2] = 32'h77726c64; pat[3] = 32'h68656c6f;

    // Reset state
    #12;
    check("rst_ctrl", {58'd0, in_ready, blk_valid, blk_first, blk_last, busy, 1'b0}, 64'd0);
    check_blk("rst_data", blk_data, '0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_in_ready_low", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    check("rst_in_ready_rise", {63'd0, in_ready}, 64'd1);

    // Single-word messages
    foreach (vecs[k]) begin
      send_word(vecs[k].data, 1'b1, vecs[k].nb);
      check($sformatf("vec%0d_latency", k), {63'd0, blk_valid}, 64'd1);
      get_block(got, gf, gl);
      exp = put(put(put('0, 0, vecs[k].w0), 1, vecs[k].w1), 15, vecs[k].w15);
      check_blk($sformatf("vec%0d_data", k), got, exp);
      check($sformatf("vec%0d_flags", k), {62'd0, gf, gl}, 64'd3);
      check($sformatf("vec%0d_idle", k), {63'd0, busy}, 64'd0);
    end

    // 56-byte message: marker fits, length spills into a pad block
    for (int i = 0; i < 13; i++) send_word(32'h34333232, 1'b0, 3'd0);
    send_word(32'h34333232, 1'b1, 3'd4);
    check("m56_busy", {63'd0, busy}, 64'd1);
    get_block(got, gf, gl);
    exp = '0;
    for (int i = 0; i < 14; i++) exp = put(exp, i, 32'h34333232);
    exp = put(exp, 14, 32'h80000000);
    check_blk("m56_blk0", got, exp);
    check("m56_blk0_flags", {62'd0, gf, gl}, 64'd2);
    get_block(got, gf, gl);
    check_blk("m56_blk1", got, put('0, 15, 32'h000001C0));
    check("m56_blk1_flags", {62'd0, gf, gl}, 64'd1);

    // 64-byte message: data-only block, then marker + length block
    for (int i = 0; i < 15; i++) send_word(pat[i%4], 1'b0, 3'd0);
    send_word(pat[3], 1'b1, 3'd4);
    get_block(got, gf, gl);
    exp = '0;
    for (int i = 0; i < 16; i++) exp = put(exp, i, pat[i%4]);
    check_blk("m64_blk0", got, exp);
    check("m64_blk0_flags", {62'd0, gf, gl}, 64'd2);
    get_block(got, gf, gl);
    check_blk("m64_blk1", got, put(put('0, 0, 32'h80000000), 15, 32'h00000200));
    check("m64_blk1_flags", {62'd0, gf, gl}, 64'd1);

    // Backpressure
    send_word(32'h61626300, 1'b1, 3'd3);
    @(negedge clk);
    hold_d = blk_data;
    check_blk("bp_initial", hold_d, put(put('0, 0, 32'h61626380), 15, 32'h18));
    for (int i = 0; i < 10; i++) begin
      check_blk($sformatf("bp_hold_data%0d", i), blk_data, hold_d);
      check($sformatf("bp_hold_ctrl%0d", i), {60'd0, blk_valid, blk_first, blk_last, in_ready}, 64'hE);
      @(negedge clk);
    end
    in_data = 32'h61626300; in_last = 1'b1; in_bytes = 3'd3; in_valid = 1'b1;
    blk_ready = 1'b1;
    @(posedge clk);
    #1;
    blk_ready = 1'b0;
    check("bp_release", {62'd0, in_ready, blk_valid}, 64'd2);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    check("bp_next_accept", {62'd0, in_ready, blk_valid}, 64'd1);
    get_block(got, gf, gl);
    check_blk("bp_next_data", got, put(put('0, 0, 32'h61626380), 15, 32'h18));

    // Back-to-back messages
    send_word(32'h61626300, 1'b1, 3'd3);
    get_block(got, gf, gl);
    check_blk("b2b_blk0", got, put(put('0, 0, 32'h61626380), 15, 32'h18));
    check("b2b_blk0_flags", {62'd0, gf, gl}, 64'd3);
    send_word(32'h68656c6f, 1'b0, 3'd0);
    send_word(32'h77000000, 1'b1, 3'd1);
    get_block(got, gf, gl);
    check_blk("b2b_blk1", got,
              put(put(put('0, 0, 32'h68656c6f), 1, 32'h77800000), 15, 32'h28));
    check("b2b_blk1_flags", {62'd0, gf, gl}, 64'd3);

    // Reset mid-fill
    for (int i = 0; i < 7; i++) send_word(32'h11111111 * (i + 1), 1'b0, 3'd0);
    check("midrst_busy", {63'd0, busy}, 64'd1);
    rst = 1'b0;
    #1;
    check("midrst_ctrl", {59'd0, in_ready, blk_valid, blk_first, blk_last, busy}, 64'd0);
    check_blk("midrst_data", blk_data, '0);
    @(negedge clk);
    rst = 1'b1;
    send_word(32'h61626300, 1'b1, 3'd3);
    get_block(got, gf, gl);
    check_blk("midrst_abc", got, put(put('0, 0, 32'h61626380), 15, 32'h18));
    check("midrst_abc_flags", {62'd0, gf, gl}, 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
